// File: rtl/ws2801_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ws2801_pkg : shared pixel/state types and default timing for the WS2801 driver
// Revision   : 1.0
// ----------------------------------------------------------------------------
package ws2801_pkg;

  localparam int BITS_PER_PIXEL   = 24;
  localparam int DEF_HALF_DIV     = 2;
  localparam int DEF_LATCH_CYCLES = 25050;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/ws2801_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ws2801_if : valid/ready pixel stream from the frame source to the driver
// Revision  : 1.0
// ----------------------------------------------------------------------------
interface ws2801_if;
  import ws2801_pkg::*;

  rgb_t pix_data;
  logic pix_valid;
  logic pix_last;
  logic pix_ready;

  modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);

endinterface
`default_nettype wire

// File: rtl/ws2801_phase_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ws2801_phase_timer : clearable elapsed-cycle counter, done on the TERMINAL-th cycle
// Revision           : 1.0
// ----------------------------------------------------------------------------
module ws2801_phase_timer #(
  parameter int WIDTH    = 2,
  parameter int TERMINAL = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  output logic      done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Saturates at TERMINAL so a timer left running never wraps into a false done.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != WIDTH'(TERMINAL)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == WIDTH'(TERMINAL));

endmodule
`default_nettype wire

// File: rtl/ws2801_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ws2801_driver : serializes 24-bit RGB pixels onto the WS2801 cki/sdi bus
// Revision      : 1.0
// ----------------------------------------------------------------------------
module ws2801_driver
  import ws2801_pkg::*;
#(
  parameter int HALF_DIV     = DEF_HALF_DIV,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ws2801_if.slave   pix,
  output logic      cki,
  output logic      sdi,
  output logic      busy,
  output logic      underrun
);

  localparam int PH_W = $clog2(HALF_DIV + 1);
  localparam int LT_W = $clog2(LATCH_CYCLES + 1);
  localparam int BC_W = $clog2(BITS_PER_PIXEL);

  if (HALF_DIV < 1 || LATCH_CYCLES < 1) begin : g_param_check
    $error("ws2801_driver: HALF_DIV and LATCH_CYCLES must both be at least 1");
  end

  drv_state_t                state_q, state_d;
  logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [LT_W-1:0]           idle_cnt_q, idle_cnt_d;
  logic                      last_q, last_d;
  logic                      in_frame_q, in_frame_d;
  logic                      cki_q, cki_d, sdi_q, sdi_d;
  logic                      ready_q, ready_d, busy_q, busy_d;
  logic                      underrun_q, underrun_d;
  logic                      transfer, timer_clr, phase_done, gap_done;

  assign transfer  = pix.pix_valid & ready_q;
  assign timer_clr = (state_d != state_q);

  ws2801_phase_timer #(.WIDTH(PH_W), .TERMINAL(HALF_DIV - 1)) u_phase_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .done (phase_done)
  );

  ws2801_phase_timer #(.WIDTH(LT_W), .TERMINAL(LATCH_CYCLES - 1)) u_gap_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .done (gap_done)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    in_frame_d = in_frame_q;
    idle_cnt_d = '0;
    underrun_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          shreg_d    = pix.pix_data;
          last_d     = pix.pix_last;
          bit_cnt_d  = BC_W'(BITS_PER_PIXEL - 1);
          in_frame_d = 1'b1;
          state_d    = LOW;
        end else if (in_frame_q) begin
          // A stall this long lets the strip latch what it has, so the frame is over.
          if (idle_cnt_q == LT_W'(LATCH_CYCLES - 1)) begin
            underrun_d = 1'b1;
            in_frame_d = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + LT_W'(1);
          end
        end
      end
      LOW: begin
        if (phase_done) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_done) begin
          shreg_d = {shreg_q[BITS_PER_PIXEL-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            if (last_q) begin
              state_d    = LATCH;
              in_frame_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - BC_W'(1);
            state_d   = LOW;
          end
        end
      end
      LATCH: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = LATCH;
    endcase

    // Outputs follow the next state so they are registered yet aligned with it.
    cki_d   = (state_d == HIGH);
    sdi_d   = (state_d == LOW || state_d == HIGH) ? shreg_d[BITS_PER_PIXEL-1] : 1'b0;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LATCH;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      last_q     <= 1'b0;
      in_frame_q <= 1'b0;
      cki_q      <= 1'b0;
      sdi_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      last_q     <= last_d;
      in_frame_q <= in_frame_d;
      cki_q      <= cki_d;
      sdi_q      <= sdi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign pix.pix_ready = ready_q;
  assign cki           = cki_q;
  assign sdi           = sdi_q;
  assign busy          = busy_q;
  assign underrun      = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2801_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ws2801_driver : bus-level checks plus a 5-LED WS2801 strip model
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_ws2801_driver;

  localparam int HD = 2;
  localparam int LC = 300;
  localparam int NLED = 5;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n;
  logic cki, sdi, busy, underrun;
  logic cki1, sdi1, busy1, underrun1;

  ws2801_if pif ();
  ws2801_if pif1 ();

  ws2801_driver #(.HALF_DIV(HD), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n), .pix(pif.slave),
    .cki(cki), .sdi(sdi), .busy(busy), .underrun(underrun)
  );

  ws2801_driver #(.HALF_DIV(1), .LATCH_CYCLES(LC)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix(pif1.slave),
    .cki(cki1), .sdi(sdi1), .busy(busy1), .underrun(underrun1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Strip model: each LED keeps the first 24 bits it sees, passes the rest on,
  // and displays them once the clock has been low for the latch gap.
  logic        bits[$];
  logic [23:0] led[NLED];
  logic [23:0] last24, last24_1;
  logic        cki_p = 1'b0, sdi_p = 1'b0, cki1_p = 1'b0;
  int          hi_len = 0, low_cnt = 0, rises = 0, hi_bad = 0, sdi_bad = 0, ur_cnt = 0;
  int          cyc = 0, rises1 = 0, hi_len1 = 0, hi_bad1 = 0, first_rise1 = 0, last_rise1 = 0;

  initial for (int i = 0; i < NLED; i++) led[i] = 24'h0;

  always @(negedge clk) begin
    cyc++;
    if (cki && !cki_p) begin
      bits.push_back(sdi);
      last24 = {last24[22:0], sdi};
      rises++;
      hi_len = 1;
    end else if (cki) begin
      hi_len++;
      if (sdi !== sdi_p) sdi_bad++;
    end
    if (!cki && cki_p && hi_len != HD) hi_bad++;
    if (!cki) low_cnt++; else low_cnt = 0;
    if (low_cnt == LC) begin
      for (int i = 0; i < NLED; i++) begin
        if (bits.size() >= 24 * (i + 1)) begin
          logic [23:0] v;
          v = 24'h0;
          for (int b = 0; b < 24; b++) v = {v[22:0], bits[24 * i + b]};
          led[i] = v;
        end
      end
      bits.delete();
    end
    if (underrun) ur_cnt++;
    cki_p = cki;
    sdi_p = sdi;

    if (cki1 && !cki1_p) begin
      if (rises1 == 0) first_rise1 = cyc;
      last_rise1 = cyc;
      last24_1 = {last24_1[22:0], sdi1};
      rises1++;
      hi_len1 = 1;
    end else if (cki1) begin
      hi_len1++;
    end
    if (!cki1 && cki1_p && hi_len1 != 1) hi_bad1++;
    cki1_p = cki1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [23:0] d, input logic last, output int waited);
    pif.pix_data  = d;
    pif.pix_last  = last;
    pif.pix_valid = 1'b1;
    waited = 0;
    while (!pif.pix_ready && waited < 48 * HD + LC + 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    pif.pix_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!pif.pix_ready && n < 48 * HD + LC + 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [23:0] fr[NLED];
  logic [23:0] exp_led[NLED];

  task automatic run_frame(input int npx);
    int w, n;
    rises = 0; hi_bad = 0; sdi_bad = 0;
    for (int i = 0; i < npx; i++) begin
      send(fr[i], (i == npx - 1), w);
      check("ready_wait", w, (i == 0) ? 0 : 48 * HD);
    end
    wait_ready(n);
    check("frame_to_ready", n, 48 * HD + LC);
    repeat (2) @(negedge clk);
    check("cki_rises", rises, 24 * npx);
    check("cki_high_len", hi_bad, 0);
    check("sdi_stable_high", sdi_bad, 0);
    for (int i = 0; i < npx; i++) exp_led[i] = fr[i];
    for (int i = 0; i < NLED; i++) check($sformatf("led%0d", i), led[i], exp_led[i]);
  endtask

  initial begin
    int n, w, cki_hi;
    for (int i = 0; i < NLED; i++) exp_led[i] = 24'h0;
    rst_n = 1'b0;
    pif.pix_valid = 1'b1; pif.pix_data = 24'hA5C30F; pif.pix_last = 1'b1;
    pif1.pix_valid = 1'b0; pif1.pix_data = 24'h0; pif1.pix_last = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ready", pif.pix_ready, 0);
    check("rst_cki", cki, 0);
    check("rst_sdi", sdi, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);

    // Reset release with valid held: one full latch gap before the first transfer.
    rst_n = 1'b1;
    n = 0; cki_hi = 0;
    while (!pif.pix_ready && n < LC + 20) begin
      if (cki) cki_hi++;
      @(negedge clk);
      n++;
    end
    check("gap_after_reset", n, LC);
    check("cki_low_in_gap", cki_hi, 0);
    rises = 0; hi_bad = 0; sdi_bad = 0;
    @(negedge clk);
    pif.pix_valid = 1'b0;
    check("busy_shift", busy, 1);
    wait_ready(n);
    check("a5_frame_to_ready", n, 48 * HD + LC);
    repeat (2) @(negedge clk);
    check("a5_rises", rises, 24);
    check("a5_bits", last24, 24'hA5C30F);
    check("a5_high_len", hi_bad, 0);
    check("a5_sdi_stable", sdi_bad, 0);
    exp_led[0] = 24'hA5C30F;
    check("a5_led0", led[0], exp_led[0]);

    // Five-pixel frame, then two random-length random-colour frames.
    for (int i = 0; i < NLED; i++) fr[i] = 24'hFFF000;
    run_frame(5);
    repeat (2) begin
      int np;
      np = $urandom_range(1, NLED);
      for (int i = 0; i < NLED; i++) fr[i] = 24'($urandom);
      run_frame(np);
    end

    // Mid-frame stall: one underrun after exactly LC idle cycles.
    for (int i = 0; i < 3; i++) fr[i] = 24'($urandom);
    send(fr[0], 1'b0, w);
    send(fr[1], 1'b0, w);
    wait_ready(n);
    check("stall_ready", n, 48 * HD);
    ur_cnt = 0;
    n = 0;
    while (!underrun && n < LC + 20) begin
      @(negedge clk);
      n++;
    end
    check("underrun_delay", n, LC);
    check("busy_in_stall", busy, 0);
    repeat (10) @(negedge clk);
    check("underrun_once", ur_cnt, 1);
    exp_led[0] = fr[0]; exp_led[1] = fr[1];
    check("stall_led0", led[0], exp_led[0]);
    check("stall_led1", led[1], exp_led[1]);
    fr[0] = fr[2];
    run_frame(1);

    // Transfer on the expiry cycle beats the underrun.
    for (int i = 0; i < 3; i++) fr[i] = 24'($urandom);
    send(fr[0], 1'b0, w);
    send(fr[1], 1'b0, w);
    wait_ready(n);
    check("expiry_ready", n, 48 * HD);
    repeat (LC - 1) @(negedge clk);
    ur_cnt = 0;
    send(fr[2], 1'b1, w);
    check("expiry_wait", w, 0);
    wait_ready(n);
    check("expiry_frame", n, 48 * HD + LC);
    repeat (2) @(negedge clk);
    check("expiry_no_underrun", ur_cnt, 0);
    exp_led[0] = fr[2]; exp_led[1] = fr[1];
    check("expiry_led0", led[0], exp_led[0]);
    check("expiry_led1", led[1], exp_led[1]);

    // Reset in the high phase of bit 12.
    send(24'hFFFFFF, 1'b1, w);
    n = 0;
    while (!(rises >= 12 && cki) && n < 48 * HD + 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_bus", {30'd0, cki, sdi}, 32'd3);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_bus", {30'd0, cki, sdi}, 32'd0);
    check("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!pif.pix_ready && n < LC + 20) begin
      @(negedge clk);
      n++;
    end
    check("gap_after_rst2", n, LC);
    fr[0] = 24'h555555;
    run_frame(1);

    // HALF_DIV = 1 instance: 2-clk bit period.
    n = 0;
    while (!pif1.pix_ready && n < LC + 20) begin
      @(negedge clk);
      n++;
    end
    check("hd1_ready", pif1.pix_ready, 1);
    rises1 = 0; hi_bad1 = 0;
    pif1.pix_data = 24'h800001; pif1.pix_last = 1'b1; pif1.pix_valid = 1'b1;
    @(negedge clk);
    pif1.pix_valid = 1'b0;
    repeat (60) @(negedge clk);
    check("hd1_rises", rises1, 24);
    check("hd1_bits", last24_1, 24'h800001);
    check("hd1_high_len", hi_bad1, 0);
    check("hd1_period", last_rise1 - first_rise1, 46);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
